// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic op codes, sequencer state encoding and a
// counter-width helper.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational slice datapath: every logic function is formed from
// nand_wordgate instances, then one of them is selected by op.
module logic_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W-1:0] na, nb, t, at, bt, f_and, f_or, f_xor, f_nor, f_xnor, f_pass;

  // Inverters are NANDs with both inputs tied together.
  nand_wordgate #(.W(W)) u_na   (.a(a),     .b(a),     .y(na));
  nand_wordgate #(.W(W)) u_nb   (.a(b),     .b(b),     .y(nb));
  nand_wordgate #(.W(W)) u_t    (.a(a),     .b(b),     .y(t));
  nand_wordgate #(.W(W)) u_and  (.a(t),     .b(t),     .y(f_and));
  nand_wordgate #(.W(W)) u_or   (.a(na),    .b(nb),    .y(f_or));
  nand_wordgate #(.W(W)) u_nor  (.a(f_or),  .b(f_or),  .y(f_nor));
  // Classic four-NAND XOR built on the shared t = ~(a & b).
  nand_wordgate #(.W(W)) u_at   (.a(a),     .b(t),     .y(at));
  nand_wordgate #(.W(W)) u_bt   (.a(b),     .b(t),     .y(bt));
  nand_wordgate #(.W(W)) u_xor  (.a(at),    .b(bt),    .y(f_xor));
  nand_wordgate #(.W(W)) u_xnor (.a(f_xor), .b(f_xor), .y(f_xnor));
  nand_wordgate #(.W(W)) u_pass (.a(na),    .b(na),    .y(f_pass));

  // Select the requested function.
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = f_and;
      OP_OR:   y = f_or;
      OP_XOR:  y = f_xor;
      OP_NAND: y = t;
      OP_NOR:  y = f_nor;
      OP_XNOR: y = f_xnor;
      OP_NOT:  y = na;
      OP_PASS: y = f_pass;
    endcase
  end

endmodule

// File: rtl/nand_wordgate.sv
// Word-wide two-input NAND gate; the only primitive used by logic_slice.
module nand_wordgate #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/logic_slice_seq.sv
// Multi-cycle bitwise logic unit: captures an operation, evaluates it one
// SW-bit slice per cycle through logic_slice, then presents a registered
// result with a one-cycle done pulse. W must be a multiple of SW.
// Optional zero/neg result flags are built when LOGIC_FLAGS_EN is defined.
module logic_slice_seq
  import alu_pkg::*;
#(
  parameter int unsigned W  = 64,
  parameter int unsigned SW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out
`ifdef LOGIC_FLAGS_EN
  ,
  output logic         zero,
  output logic         neg
`endif
);

  localparam int unsigned NSLICE = W / SW;
  localparam int unsigned CntW   = cnt_width(NSLICE);
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  out_q, out_d;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
`ifdef LOGIC_FLAGS_EN
  logic          zero_q, zero_d, neg_q, neg_d;
`endif

  int unsigned   slice_lo;
  logic [SW-1:0] slice_y;

  // Bit offset of the slice handled this cycle.
  always_comb begin
    slice_lo = SW * 32'(cnt_q);
  end

  logic_slice #(.W(SW)) u_slice (
    .op (op_q),
    .a  (a_q[slice_lo +: SW]),
    .b  (b_q[slice_lo +: SW]),
    .y  (slice_y)
  );

  // Next-state logic: capture, per-slice accumulation and result load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
`ifdef LOGIC_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = in_0;
          b_d     = in_1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[slice_lo +: SW] = slice_y;
        if (cnt_q == LastCnt) begin
          // Load from acc_d so the final slice is included.
          out_d   = acc_d;
`ifdef LOGIC_FLAGS_EN
          zero_d  = (acc_d == '0);
          neg_d   = acc_d[W-1];
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered, so derive them from the next state.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOGIC_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOGIC_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
`ifdef LOGIC_FLAGS_EN
  assign zero  = zero_q;
  assign neg   = neg_q;
`endif

endmodule

// File: tb/tb_logic_slice_seq.sv
// Scoreboard bench for logic_slice_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_logic_slice_seq;
  import alu_pkg::*;

  localparam int unsigned W      = 64;
  localparam int unsigned SW     = 16;
  localparam int unsigned NSLICE = W / SW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] in_0 = '0;
  logic [W-1:0] in_1 = '0;
  logic         ready, busy, done;
  logic [W-1:0] out;
`ifdef LOGIC_FLAGS_EN
  logic         zero, neg;
`endif

  logic_slice_seq #(.W(W), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .in_0  (in_0),
    .in_1  (in_1),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out)
`ifdef LOGIC_FLAGS_EN
    ,
    .zero  (zero),
    .neg   (neg)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] res;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: done-driven scoreboard plus per-cycle status/hold checks.
  logic [W-1:0] last_out = '0;
  int           ready_low = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_out  = '0;
      ready_low = 0;
    end else begin
      check("busy_vs_ready", W'(busy), W'(!ready));
      if (!ready) ready_low++;
      else begin
        if (ready_low > 0) check("ready_low_cycles", W'(ready_low), W'(NSLICE + 1));
        ready_low = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual done=1 required done=0 (out %h)", out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out", out, e.res);
          check("latency", W'(cyc - e.acc_cyc), W'(NSLICE));
`ifdef LOGIC_FLAGS_EN
          check("zero", W'(zero), W'(e.res == '0));
          check("neg", W'(neg), W'(e.res[W-1]));
`endif
          last_out = e.res;
        end
      end else begin
        check("out_hold", out, last_out);
      end
    end
  end

  // Drive a request and wait (bounded) until it is accepted.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] req, input bit drop);
    int n = 0;
    start = 1'b1;
    op    = o;
    in_0  = a;
    in_1  = b;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual ready=0 required ready=1");
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back('{res: req, acc_cyc: cyc});
    last_acc = cyc;
    if (drop) start = 1'b0;
  endtask

  initial begin
    int n;
    int prev;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state.
    #12;
    check("rst_ready", W'(ready), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_out", out, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    issue(3'b011, 64'hFFFF0000FFFF0000, 64'hFF00FF00FF00FF00, 64'h00FFFFFF00FFFFFF, 1);
    issue(3'b010, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1);
    issue(3'b000, 64'h123456789ABCDEF0, 64'h0, 64'h0, 1);
    issue(3'b110, 64'h0, 64'hDEADBEEF, 64'hFFFFFFFFFFFFFFFF, 1);

    // Request held high while busy is ignored until ready returns.
    issue(3'b001, 64'hF0, 64'h0F, 64'hFF, 0);
    issue(3'b000, 64'h0F0F, 64'h00FF, 64'h000F, 1);

    // Reset during the second RUN cycle aborts the NOR.
    issue(3'b100, 64'h1, 64'h2, 64'h0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    #2;
    check("abort_out", out, '0);
    check("abort_ready", W'(ready), W'(1));
    check("abort_done", W'(done), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", W'(ready), W'(1));
    check("post_rst_out", out, '0);
    @(posedge clk);
    #1;
    issue(3'b101, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFFFFFFFFFF, 1);

    // Back-to-back with start held high.
    issue(3'b111, 64'h8000000000000001, 64'h0, 64'h8000000000000001, 0);
    for (int i = 0; i < 3; i++) begin
      prev = last_acc;
      issue(3'b111, 64'h8000000000000001, 64'h5A, 64'h8000000000000001, 0);
      check("b2b_period", W'(last_acc - prev), W'(NSLICE + 2));
    end
    start = 1'b0;

    // Randomized operations; inputs scrambled after capture.
    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) rb = ra;
      issue(ro, ra, rb, model(ro, ra, rb), 1);
      op   = 3'($urandom_range(0, 7));
      in_0 = {$urandom, $urandom};
      in_1 = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Drain the scoreboard.
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual %0d pending required 0 pending", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
